// File: rtl/arqte1_mem_loader.sv
// arqte1_mem_loader: byte-stream to 32-bit RAM image loader.
// Packs accepted bytes little-endian into words and writes them to
// consecutive RAM word addresses starting at BASE_ADDR.
// Optional feature macro: ARQTE1_LOADER_CHECKSUM_EN (mod-256 byte checksum).
module arqte1_mem_loader #(
   parameter int ADDR_W    = 12,
   parameter int BASE_ADDR = 0,
   parameter int LAST_ADDR = 2048
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic [ADDR_W-1:0] mem_address,
   output logic [3:0]        mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [31:0]       mem_writedata,
   output logic              mem_clken,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic [ADDR_W:0]   words_written,
   output logic [7:0]        checksum
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_WRITE,
      S_DONE
   } state_t;

   state_t      state;
   logic [1:0]  lane;
   logic        last_seen;
   logic        accept;

   // in_ready is only ever high in FILL, so this is the byte handshake
   assign accept    = (state == S_FILL) && in_valid && in_ready;
   assign mem_clken = 1'b1;

   // Load sequencer: fill a word lane by lane, write it in one cycle, repeat
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= S_IDLE;
         lane           <= '0;
         last_seen      <= 1'b0;
         in_ready       <= 1'b0;
         mem_address    <= ADDR_W'(BASE_ADDR);
         mem_byteenable <= '0;
         mem_chipselect <= 1'b0;
         mem_write      <= 1'b0;
         mem_writedata  <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         overflow       <= 1'b0;
         words_written  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state          <= S_FILL;
                  in_ready       <= 1'b1;
                  busy           <= 1'b1;
                  lane           <= '0;
                  last_seen      <= 1'b0;
                  mem_byteenable <= '0;
                  mem_writedata  <= '0;
                  mem_address    <= ADDR_W'(BASE_ADDR);
                  words_written  <= '0;
                  overflow       <= 1'b0;
               end
            end
            S_FILL: begin
               if (accept) begin
                  mem_writedata[{lane, 3'b000} +: 8] <= in_data;
                  mem_byteenable[lane]               <= 1'b1;
                  if (lane == 2'd3 || in_last) begin
                     state          <= S_WRITE;
                     in_ready       <= 1'b0;
                     mem_chipselect <= 1'b1;
                     mem_write      <= 1'b1;
                     last_seen      <= in_last;
                  end else begin
                     lane <= lane + 2'd1;
                  end
               end
            end
            S_WRITE: begin
               mem_chipselect <= 1'b0;
               mem_write      <= 1'b0;
               words_written  <= words_written + (ADDR_W + 1)'(1);
               if (last_seen) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end else if (mem_address == ADDR_W'(LAST_ADDR)) begin
                  state    <= S_DONE;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  overflow <= 1'b1;
               end else begin
                  state          <= S_FILL;
                  in_ready       <= 1'b1;
                  mem_address    <= mem_address + ADDR_W'(1);
                  lane           <= '0;
                  mem_byteenable <= '0;
                  mem_writedata  <= '0;
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef ARQTE1_LOADER_CHECKSUM_EN
   logic [7:0] sum;
   assign checksum = sum;

   // Running mod-256 sum of accepted bytes; cleared by an accepted start
   always_ff @(posedge clk) begin
      if (reset) begin
         sum <= '0;
      end else if (state == S_IDLE && start) begin
         sum <= '0;
      end else if (accept) begin
         sum <= sum + in_data;
      end
   end
`else
   assign checksum = '0;
`endif

endmodule
